// File: rtl/exec_seq.sv
// exec_seq: one instruction in flight; simple ops answer on the acceptance edge, MLT/DIV iterate and answer 33 edges later.
// Optional DIV_ZERO_FLAG_EN adds a div0 output that flags a DIV whose divisor was zero.
module exec_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_opcode,
  input  logic [6:0]  in_rd,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  input  logic [31:0] in_rsi,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_opcode,
  output logic [6:0]  out_rd,
  output logic [31:0] out_result,
  output logic [6:0]  out_branch,
`ifdef DIV_ZERO_FLAG_EN
  output logic        div0,
`endif
  output logic        busy
);
  localparam logic [4:0] OP_LV   = 5'd1;
  localparam logic [4:0] OP_MLT  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_REST = 5'd4;
  localparam logic [4:0] OP_SUM  = 5'd5;
  localparam logic [4:0] OP_CP   = 5'd6;
  localparam logic [4:0] OP_B    = 5'd7;
  localparam logic [4:0] OP_BEG  = 5'd8;
  localparam logic [4:0] OP_SLR  = 5'd9;
  localparam logic [4:0] OP_GP   = 5'd10;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] opa;   // MUL: shifted multiplicand, DIV: divisor
  logic [31:0] opb;   // MUL: shifted multiplier,   DIV: dividend becoming quotient
  logic [31:0] acc;
  logic [31:0] rem;
  logic [4:0]  op_q;
  logic [6:0]  rd_q;
  logic        accept;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready && !flush;

  logic [31:0] s_result;
  logic [6:0]  s_branch;
  logic [6:0]  s_rd;
  logic        s_emit;

  always_comb begin
    s_result = '0;
    s_branch = '0;
    s_rd     = in_rd;
    s_emit   = 1'b1;
    case (in_opcode)
      OP_LV, OP_CP: s_result = in_rsi;
      OP_REST:      s_result = in_rs - in_rt;
      OP_SUM:       s_result = in_rs + in_rt;
      OP_GP:        s_result = in_rs;
      OP_SLR:       s_result = (in_rt >= 32'd32) ? 32'd0 : (in_rs << in_rt[4:0]);
      OP_B: begin
        s_branch = in_rd;
        s_rd     = '0;
      end
      OP_BEG: begin
        s_rd = '0;
        if ({25'b0, in_rd} > in_rs) s_branch = in_rt[6:0];
      end
      default: s_emit = 1'b0;
    endcase
  end

  // One restoring-division step: bit 32 of the difference is the borrow.
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;
  assign rem_sh   = {rem, opb[31]};
  assign rem_diff = rem_sh - {1'b0, opa};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      out_opcode <= '0;
      out_rd     <= '0;
      out_result <= '0;
      out_branch <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        MUL, DIV: begin
          if (cnt == 6'd32) begin
            state      <= DONE;
            busy       <= 1'b0;
            out_valid  <= 1'b1;
            out_opcode <= op_q;
            out_rd     <= rd_q;
            out_result <= (state == MUL) ? acc : opb;
            out_branch <= '0;
          end else begin
            cnt <= cnt + 6'd1;
            if (state == MUL) begin
              if (opb[0]) acc <= acc + opa;
              opa <= opa << 1;
              opb <= opb >> 1;
            end else begin
              rem <= rem_diff[32] ? rem_sh[31:0] : rem_diff[31:0];
              opb <= {opb[30:0], !rem_diff[32]};
            end
          end
        end
        default: begin
          if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
          if (accept) begin
            op_q <= in_opcode;
            rd_q <= in_rd;
            cnt  <= '0;
            if (in_opcode == OP_MLT) begin
              state <= MUL;
              busy  <= 1'b1;
              opa   <= in_rs;
              opb   <= in_rt;
              acc   <= '0;
            end else if (in_opcode == OP_DIV) begin
              state <= DIV;
              busy  <= 1'b1;
              opa   <= in_rt;
              opb   <= in_rs;
              rem   <= '0;
            end else if (s_emit) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_opcode <= in_opcode;
              out_rd     <= s_rd;
              out_result <= s_result;
              out_branch <= s_branch;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic dz_q;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      dz_q <= 1'b0;
      div0 <= 1'b0;
    end else begin
      if (accept && in_opcode == OP_DIV) dz_q <= (in_rt == 32'd0);
      if (state == DIV && cnt == 6'd32) div0 <= dz_q;
      else if (state == DONE && out_ready) div0 <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_exec_seq.sv
// Bench for exec_seq: directed vectors with literal expectations plus a per-cycle reference model.
module tb_exec_seq;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0]  in_opcode, out_opcode;
  logic [6:0]  in_rd, out_rd, out_branch;
  logic [31:0] in_rs, in_rt, in_rsi, out_result;
`ifdef DIV_ZERO_FLAG_EN
  logic        div0;
`endif
  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  exec_seq dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs(in_rs), .in_rt(in_rt), .in_rsi(in_rsi),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_rd(out_rd),
    .out_result(out_result), .out_branch(out_branch),
`ifdef DIV_ZERO_FLAG_EN
    .div0(div0),
`endif
    .busy(busy)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a result is either being computed (countdown) or presented.
  logic        m_vld = 1'b0, m_busy = 1'b0, m_d0 = 1'b0, p_d0 = 1'b0, m_acc;
  int          m_cnt = 0;
  logic [4:0]  m_op = '0, p_op = '0;
  logic [6:0]  m_rd = '0, p_rd = '0, m_br = '0;
  logic [31:0] m_res = '0, p_res = '0;

  function automatic logic m_rdy();
    return (!m_busy && !m_vld) || (m_vld && out_ready);
  endfunction

  task automatic m_emit(input logic [31:0] res, input logic [6:0] rd, input logic [6:0] br);
    m_vld = 1'b1; m_op = in_opcode; m_rd = rd; m_res = res; m_br = br; m_d0 = 1'b0;
  endtask

  task automatic m_accept();
    case (in_opcode)
      5'd2, 5'd3: begin
        m_busy = 1'b1; m_cnt = 33; p_op = in_opcode; p_rd = in_rd;
        p_d0  = (in_opcode == 5'd3) && (in_rt == 0);
        p_res = (in_opcode == 5'd2) ? in_rs * in_rt : ((in_rt == 0) ? 32'hFFFF_FFFF : in_rs / in_rt);
      end
      5'd1, 5'd6: m_emit(in_rsi, in_rd, 7'd0);
      5'd4:  m_emit(in_rs - in_rt, in_rd, 7'd0);
      5'd5:  m_emit(in_rs + in_rt, in_rd, 7'd0);
      5'd10: m_emit(in_rs, in_rd, 7'd0);
      5'd9:  m_emit((in_rt >= 32) ? 32'd0 : in_rs << in_rt, in_rd, 7'd0);
      5'd7:  m_emit(32'd0, 7'd0, in_rd);
      5'd8:  m_emit(32'd0, 7'd0, (32'(in_rd) > in_rs) ? in_rt[6:0] : 7'd0);
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    m_acc = in_valid && m_rdy() && !flush;
    if (rst) begin
      m_vld = 1'b0; m_busy = 1'b0; m_cnt = 0; m_d0 = 1'b0;
    end else if (flush) begin
      m_vld = 1'b0; m_busy = 1'b0; m_cnt = 0;
    end else begin
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0; m_vld = 1'b1;
          m_op = p_op; m_rd = p_rd; m_res = p_res; m_br = 7'd0; m_d0 = p_d0;
        end
      end else if (m_vld && out_ready) begin
        m_vld = 1'b0;
      end
      if (m_acc) m_accept();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_out_valid", out_valid, m_vld);
      cmp("m_busy", busy, m_busy);
      cmp("m_in_ready", in_ready, m_rdy());
      cmp("vld_busy_excl", out_valid && busy, 0);
      if (m_vld) begin
        cmp("m_out_opcode", out_opcode, m_op);
        cmp("m_out_rd", out_rd, m_rd);
        cmp("m_out_result", out_result, m_res);
        cmp("m_out_branch", out_branch, m_br);
      end
`ifdef DIV_ZERO_FLAG_EN
      cmp("m_div0", div0, m_vld && m_d0);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [4:0] op, input logic [6:0] rd, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [31:0] rsi);
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt; in_rsi = rsi;
    tick(1);
    in_valid = 1'b0;
  endtask

  // Edges from acceptance until out_valid, bounded; also counts cycles with in_ready high.
  task automatic wait_vld(output int n, output int rdy_seen);
    n = 0; rdy_seen = 0;
    while (!out_valid && n < 50) begin
      if (in_ready) rdy_seen++;
      tick(1);
      n++;
    end
  endtask

  logic [4:0]  t_op  [5] = '{5'd4, 5'd9, 5'd1, 5'd10, 5'd9};
  logic [31:0] t_rs  [5] = '{32'd3, 32'd3, 32'd0, 32'd77, 32'd1};
  logic [31:0] t_rt  [5] = '{32'd5, 32'd40, 32'd0, 32'd0, 32'd4};
  logic [31:0] t_rsi [5] = '{32'd0, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0};
  logic [31:0] t_exp [5] = '{32'hFFFF_FFFE, 32'd0, 32'hDEAD_BEEF, 32'd77, 32'd16};

  initial begin
    int n, r, seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_rsi = '0;
    tick(2);
    chk_en = 1'b1;
    cmp("rst_out_valid", out_valid, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_out_opcode", out_opcode, 0);
    cmp("rst_out_rd", out_rd, 0);
    cmp("rst_out_result", out_result, 0);
    cmp("rst_out_branch", out_branch, 0);
    cmp("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick(1);

    send(5'd5, 7'd3, 32'd5, 32'd7, 32'd0);
    cmp("sum_valid", out_valid, 1);
    cmp("sum_result", out_result, 12);
    cmp("sum_rd", out_rd, 3);
    cmp("sum_opcode", out_opcode, 5);
    tick(1);

    send(5'd3, 7'd4, 32'd100, 32'd7, 32'd0);
    cmp("div_busy", busy, 1);
    wait_vld(n, r);
    cmp("div_latency", n, 33);
    cmp("div_result", out_result, 14);
    tick(1);

    send(5'd3, 7'd5, 32'd55, 32'd0, 32'd0);
    wait_vld(n, r);
    cmp("div0_latency", n, 33);
    cmp("div0_result", out_result, 32'hFFFF_FFFF);
`ifdef DIV_ZERO_FLAG_EN
    cmp("div0_flag", div0, 1);
`endif
    tick(1);

    send(5'd2, 7'd6, 32'h0001_0000, 32'h0001_0001, 32'd0);
    wait_vld(n, r);
    cmp("mlt_latency", n, 33);
    cmp("mlt_in_ready_seen", r, 0);
    cmp("mlt_result", out_result, 32'h0001_0000);
    tick(1);

    send(5'd8, 7'd10, 32'd3, 32'd42, 32'd0);
    cmp("beg_taken", out_branch, 42);
    cmp("beg_rd", out_rd, 0);
    tick(1);
    send(5'd8, 7'd3, 32'd10, 32'd42, 32'd0);
    cmp("beg_not_taken", out_branch, 0);
    tick(1);
    send(5'd7, 7'd9, 32'd0, 32'd0, 32'd0);
    cmp("b_branch", out_branch, 9);
    cmp("b_rd", out_rd, 0);
    cmp("b_result", out_result, 0);
    tick(1);

    for (int i = 0; i < 5; i++) begin
      send(t_op[i], 7'd20, t_rs[i], t_rt[i], t_rsi[i]);
      cmp("table_result", out_result, t_exp[i]);
      tick(1);
    end

    send(5'd0, 7'd1, 32'd1, 32'd1, 32'd1);
    cmp("nop_no_valid", out_valid, 0);
    send(5'd20, 7'd1, 32'd1, 32'd1, 32'd1);
    cmp("undef_no_valid", out_valid, 0);
    cmp("undef_in_ready", in_ready, 1);

    out_ready = 1'b0;
    send(5'd5, 7'd5, 32'd100, 32'd23, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      cmp("hold_valid", out_valid, 1);
      cmp("hold_result", out_result, 123);
      cmp("hold_rd", out_rd, 5);
    end
    out_ready = 1'b1;
    send(5'd9, 7'd6, 32'd1, 32'd31, 32'd0);
    cmp("b2b_valid", out_valid, 1);
    cmp("b2b_result", out_result, 32'h8000_0000);
    cmp("b2b_opcode", out_opcode, 9);
    tick(1);

    send(5'd3, 7'd7, 32'd1000, 32'd3, 32'd0);
    tick(9);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    cmp("flush_busy", busy, 0);
    cmp("flush_valid", out_valid, 0);
    cmp("flush_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (out_valid) seen++;
    end
    cmp("flush_no_result", seen, 0);

    send(5'd2, 7'd8, 32'd7, 32'd9, 32'd0);
    tick(5);
    rst = 1'b1;
    tick(1);
    cmp("rstmid_valid", out_valid, 0);
    cmp("rstmid_busy", busy, 0);
    cmp("rstmid_opcode", out_opcode, 0);
    cmp("rstmid_rd", out_rd, 0);
    cmp("rstmid_result", out_result, 0);
    cmp("rstmid_branch", out_branch, 0);
    rst = 1'b0;
    tick(1);
    send(5'd5, 7'd2, 32'd1, 32'd1, 32'd0);
    cmp("post_rst_sum", out_result, 2);
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end
endmodule
